// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - Start/Busy/Done handshake and HI/LO access bundle for hilo_muldiv_unit
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic [WIDTH-1:0] inHigh;
    logic [WIDTH-1:0] inLow;
    logic             HIWrite;
    logic             LOWrite;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             Busy;
    logic             Done;
    logic             DivByZero;

    modport master (
        output Start, Op, OpA, OpB, inHigh, inLow, HIWrite, LOWrite,
        input  HI, LO, Busy, Done, DivByZero
    );

    modport slave (
        input  Start, Op, OpA, OpB, inHigh, inLow, HIWrite, LOWrite,
        output HI, LO, Busy, Done, DivByZero
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - HI/LO register pair with iterative shift-add multiply / restoring divide
// Define HILO_MAC_EN to make MADD/MSUB legal and build the 2*WIDTH accumulate path.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic               Clk,
    input logic               Rst,
    hilo_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             state;
    logic [2:0]         op_r;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   mag;
    logic [2*WIDTH-1:0] prod;
    logic               neg_q;
    logic               neg_r;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic               op_legal;
    logic               op_signed;
    logic               op_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               run_div;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_shift;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH-1:0] step_next;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic               div_zero;

    assign bus.HI        = hi_q;
    assign bus.LO        = lo_q;
    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DivByZero = dbz_q;

    always_comb begin
        op_legal = (bus.Op <= OP_DIVU);
`ifdef HILO_MAC_EN
        op_legal = op_legal || (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);
`endif
        op_signed = (bus.Op == OP_MULT) || (bus.Op == OP_DIV) ||
                    (bus.Op == OP_MADD) || (bus.Op == OP_MSUB);
        op_div    = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
        a_mag     = (op_signed && bus.OpA[WIDTH-1]) ? -bus.OpA : bus.OpA;
        b_mag     = (op_signed && bus.OpB[WIDTH-1]) ? -bus.OpB : bus.OpB;
    end

    // prod holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        run_div   = (op_r == OP_DIV) || (op_r == OP_DIVU);
        add_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag} : '0);
        sub_shift = prod[2*WIDTH-1:WIDTH-1];
        sub_diff  = sub_shift - {1'b0, mag};
        if (run_div) begin
            step_next = sub_diff[WIDTH] ? {sub_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                        : {sub_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
        end else begin
            step_next = {add_sum, prod[WIDTH-1:1]};
        end

        div_zero = run_div && (mag == '0);
        prod_s   = neg_q ? -prod : prod;
        quo_s    = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem_s    = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        case (op_r)
            OP_DIV, OP_DIVU: result = div_zero ? {opa_r, {WIDTH{1'b1}}} : {rem_s, quo_s};
`ifdef HILO_MAC_EN
            OP_MADD:         result = {hi_q, lo_q} + prod_s;
            OP_MSUB:         result = {hi_q, lo_q} - prod_s;
`endif
            default:         result = prod_s;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= S_IDLE;
            op_r   <= OP_MULT;
            cnt    <= '0;
            opa_r  <= '0;
            mag    <= '0;
            prod   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.Start && op_legal) begin
                        op_r   <= bus.Op;
                        opa_r  <= bus.OpA;
                        mag    <= op_div ? b_mag : a_mag;
                        prod   <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        neg_q  <= op_signed && (bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1]);
                        neg_r  <= op_signed && bus.OpA[WIDTH-1];
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= S_RUN;
                    end else begin
                        if (bus.HIWrite) hi_q <= bus.inHigh;
                        if (bus.LOWrite) lo_q <= bus.inLow;
                    end
                end
                S_RUN: begin
                    prod <= step_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= S_FIN;
                end
                S_FIN: begin
                    {hi_q, lo_q} <= result;
                    done_q       <= 1'b1;
                    dbz_q        <= div_zero;
                    busy_q       <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - scoreboard bench for hilo_muldiv_unit with arithmetic reference model
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();
    hilo_muldiv_unit #(.WIDTH(W)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [2:0] op);
`ifdef HILO_MAC_EN
        return op <= 3'd5;
`else
        return op <= 3'd3;
`endif
    endfunction

    function automatic logic [64:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] hi,
                                           input logic [W-1:0] lo);
        longint      sp;
        logic [63:0] r;
        logic        dz;
        int          sq;
        int          sr;
        sp = longint'($signed(a)) * longint'($signed(b));
        dz = 1'b0;
        r  = '0;
        case (op)
            3'd0: r = sp;
            3'd1: r = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) begin
                    r  = {a, 32'hFFFF_FFFF};
                    dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = {32'd0, 32'h8000_0000};
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    r  = {sr, sq};
                end
            end
            3'd3: begin
                if (b == 0) begin
                    r  = {a, 32'hFFFF_FFFF};
                    dz = 1'b1;
                end else begin
                    r = {a % b, a / b};
                end
            end
            3'd4: r = {hi, lo} + sp;
            3'd5: r = {hi, lo} - sp;
            default: r = {hi, lo};
        endcase
        return {dz, r};
    endfunction

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every Done pops one expectation; DivByZero must stay low otherwise
    always @(negedge Clk) begin
        if (!Rst) begin
            if (bus.Done) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_done: got Done=1 expected no pending op");
                end else begin
                    mon_e = sb.pop_front();
                    check("result_hi", bus.HI, mon_e.hi);
                    check("result_lo", bus.LO, mon_e.lo);
                    check("divbyzero", bus.DivByZero, mon_e.dz);
                    check("latency", cyc, mon_e.cyc);
                end
            end else begin
                check("dbz_without_done", bus.DivByZero, 1'b0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic hw, input logic lw, input logic [W-1:0] dh,
                         input logic [W-1:0] dl);
        logic [64:0] r;
        exp_t        e;
        bit          ok;
        ok          = legal(op);
        bus.Start   = 1'b1;
        bus.Op      = op;
        bus.OpA     = a;
        bus.OpB     = b;
        bus.HIWrite = hw;
        bus.LOWrite = lw;
        bus.inHigh  = dh;
        bus.inLow   = dl;
        if (ok) begin
            r     = ref_op(op, a, b, m_hi, m_lo);
            e.hi  = r[63:32];
            e.lo  = r[31:0];
            e.dz  = r[64];
            e.cyc = cyc + W + 2;
            sb.push_back(e);
            m_hi  = e.hi;
            m_lo  = e.lo;
        end else begin
            if (hw) m_hi = dh;
            if (lw) m_lo = dl;
        end
        @(negedge Clk);
        bus.Start   = 1'b0;
        bus.HIWrite = 1'b0;
        bus.LOWrite = 1'b0;
        check(ok ? "busy_after_start" : "busy_after_illegal", bus.Busy, ok);
        if (!ok) begin
            check("hi_after_illegal", bus.HI, m_hi);
            check("lo_after_illegal", bus.LO, m_lo);
        end
    endtask

    // Returns at the negedge of the Done cycle; noise injects ignored Start/MTHI while busy
    task automatic wait_done(input bit noise);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3 * W && !seen; i++) begin
            if (bus.Done) begin
                seen = 1'b1;
            end else begin
                if (noise && bus.Busy && $urandom_range(0, 3) == 0) begin
                    bus.Start   = 1'b1;
                    bus.Op      = 3'($urandom_range(0, 7));
                    bus.OpA     = $urandom;
                    bus.OpB     = $urandom;
                    bus.HIWrite = 1'b1;
                    bus.LOWrite = 1'($urandom_range(0, 1));
                    bus.inHigh  = $urandom;
                    bus.inLow   = $urandom;
                end
                @(negedge Clk);
                bus.Start   = 1'b0;
                bus.HIWrite = 1'b0;
                bus.LOWrite = 1'b0;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no Done expected Done within %0d cycles", 3 * W);
        end else begin
            check("busy_at_done", bus.Busy, 1'b0);
        end
    endtask

    task automatic direct_write(input logic hw, input logic lw, input logic [W-1:0] dh,
                                input logic [W-1:0] dl);
        bus.HIWrite = hw;
        bus.LOWrite = lw;
        bus.inHigh  = dh;
        bus.inLow   = dl;
        if (hw) m_hi = dh;
        if (lw) m_lo = dl;
        @(negedge Clk);
        bus.HIWrite = 1'b0;
        bus.LOWrite = 1'b0;
        check("mthi", bus.HI, m_hi);
        check("mtlo", bus.LO, m_lo);
    endtask

    task automatic do_reset();
        Rst  = 1'b1;
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        #1;
        check("rst_hi", bus.HI, 32'h0);
        check("rst_lo", bus.LO, 32'h0);
        check("rst_busy", bus.Busy, 1'b0);
        check("rst_done", bus.Done, 1'b0);
        check("rst_dbz", bus.DivByZero, 1'b0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        Rst         = 1'b0;
        bus.Start   = 1'b0;
        bus.Op      = 3'd0;
        bus.OpA     = '0;
        bus.OpB     = '0;
        bus.inHigh  = '0;
        bus.inLow   = '0;
        bus.HIWrite = 1'b0;
        bus.LOWrite = 1'b0;
        m_hi        = '0;
        m_lo        = '0;
        @(negedge Clk);
        do_reset();

        issue(3'd0, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0);
        check("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO, 32'hFFFF_FFFE);

        issue(3'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0);
        check("multu_hi", bus.HI, 32'h1);
        check("multu_lo", bus.LO, 32'hFFFF_FFFE);
        // Back-to-back DIVU in the Done cycle, with a competing direct write that Start overrides
        issue(3'd3, 32'd100, 32'd7, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        wait_done(1'b0);
        check("divu_lo", bus.LO, 32'hE);
        check("divu_hi", bus.HI, 32'h2);

        issue(3'd2, 32'hFFFF_FFF9, 32'h2, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0);
        check("div_neg_lo", bus.LO, 32'hFFFF_FFFD);
        check("div_neg_hi", bus.HI, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0);
        check("div_min_lo", bus.LO, 32'h8000_0000);
        check("div_min_hi", bus.HI, 32'h0);

        issue(3'd3, 32'h1234_5678, 32'h0, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0);
        check("dz_lo", bus.LO, 32'hFFFF_FFFF);
        check("dz_hi", bus.HI, 32'h1234_5678);
        check("dz_flag", bus.DivByZero, 1'b1);
        direct_write(1'b1, 1'b0, 32'h0BAD_F00D, '0);
        repeat (3) @(negedge Clk);

        // Reset mid-op discards the operation and the ignored MTHI
        issue(3'd0, $urandom, $urandom, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge Clk);
        bus.HIWrite = 1'b1;
        bus.inHigh  = 32'hAAAA_5555;
        @(negedge Clk);
        bus.HIWrite = 1'b0;
        repeat (4) @(negedge Clk);
        do_reset();
        repeat (40) @(negedge Clk);
        check("post_rst_hi", bus.HI, 32'h0);
        check("post_rst_lo", bus.LO, 32'h0);

`ifdef HILO_MAC_EN
        direct_write(1'b1, 1'b1, 32'h0, 32'h5);
        issue(3'd4, 32'd3, 32'd4, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0);
        check("madd_lo", bus.LO, 32'h11);
        check("madd_hi", bus.HI, 32'h0);
        issue(3'd5, 32'd1, 32'h12, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0);
        check("msub_lo", bus.LO, 32'hFFFF_FFFF);
        check("msub_hi", bus.HI, 32'hFFFF_FFFF);
`else
        direct_write(1'b1, 1'b1, 32'h1111, 32'h2222);
        issue(3'd4, 32'd3, 32'd4, 1'b0, 1'b0, '0, '0);
        repeat (W + 5) @(negedge Clk);
        check("nomac_hi", bus.HI, 32'h1111);
        check("nomac_lo", bus.LO, 32'h2222);
        check("nomac_busy", bus.Busy, 1'b0);
`endif
        repeat (2) @(negedge Clk);

        for (int k = 0; k < 60; k++) begin
            op = 3'($urandom_range(0, 7));
            a  = rnd_operand();
            b  = rnd_operand();
            issue(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
            if (legal(op)) begin
                wait_done(1'b1);
                case ($urandom_range(0, 2))
                    0: ;
                    1: direct_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
                    default: repeat ($urandom_range(1, 3)) @(negedge Clk);
                endcase
            end
        end

        repeat (W + 5) @(negedge Clk);
        check("scoreboard_drained", sb.size(), 0);
        check("final_hi", bus.HI, m_hi);
        check("final_lo", bus.LO, m_lo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
